// File: rtl/fu_pkg.sv
// Shared opcode and state definitions for the multi-cycle function unit.
// Imported by the ALU, the top level and the bench.
package fu_pkg;

  localparam logic [3:0] FS_MOVA  = 4'h0;
  localparam logic [3:0] FS_INC   = 4'h1;
  localparam logic [3:0] FS_ADD   = 4'h2;
  localparam logic [3:0] FS_ADDC  = 4'h3;
  localparam logic [3:0] FS_ADDNB = 4'h4;
  localparam logic [3:0] FS_SUB   = 4'h5;
  localparam logic [3:0] FS_DEC   = 4'h6;
  localparam logic [3:0] FS_TSA   = 4'h7;
  localparam logic [3:0] FS_AND   = 4'h8;
  localparam logic [3:0] FS_OR    = 4'h9;
  localparam logic [3:0] FS_XOR   = 4'hA;
  localparam logic [3:0] FS_NOT   = 4'hB;
  localparam logic [3:0] FS_MOVB  = 4'hC;
  localparam logic [3:0] FS_SHR   = 4'hD;
  localparam logic [3:0] FS_SHL   = 4'hE;
  localparam logic [3:0] FS_MUL   = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_e;

endpackage

// File: rtl/func_unit_mc_if.sv
// Request/result bundle between the register file and the function unit.
// master issues operations, slave (the unit) returns results and flags.
interface func_unit_mc_if #(
  parameter int DW = 8
);
  logic          start;
  logic [3:0]    FS;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          busy;
  logic          done;
  logic [DW-1:0] F;
  logic          C;
  logic          V;
  logic          N;
  logic          Z;

  modport master (
    output start, FS, A, B,
    input  busy, done, F, C, V, N, Z
  );

  modport slave (
    input  start, FS, A, B,
    output busy, done, F, C, V, N, Z
  );
endinterface

// File: rtl/fu_alu_comb.sv
// Combinational ALU/shifter for all single-cycle opcodes.
// Every arithmetic op shares one adder: x + y + cin.
module fu_alu_comb
  import fu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    fs_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] r_o,
  output logic          c_o,
  output logic          v_o
);

  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          cin;
  logic [DW:0]   sum;
  logic          ovf;

  always_comb begin
    x   = a_i;
    y   = '0;
    cin = 1'b0;
    unique case (fs_i)
      FS_INC:   cin = 1'b1;
      FS_ADD:   y = b_i;
      FS_ADDC: begin
        y   = b_i;
        cin = 1'b1;
      end
      FS_ADDNB: y = ~b_i;
      FS_SUB: begin
        y   = ~b_i;
        cin = 1'b1;
      end
      FS_DEC:   y = '1;
      default:  ;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y}
             + {{DW{1'b0}}, cin};
  assign ovf = (x[DW-1] == y[DW-1])
            && (sum[DW-1] != x[DW-1]);

  always_comb begin
    r_o = '0;
    c_o = 1'b0;
    v_o = 1'b0;
    unique case (fs_i)
      FS_INC, FS_ADD, FS_ADDC,
      FS_ADDNB, FS_SUB, FS_DEC: begin
        r_o = sum[DW-1:0];
        c_o = sum[DW];
        v_o = ovf;
      end
      FS_MOVA, FS_TSA: r_o = a_i;
      FS_AND:  r_o = a_i & b_i;
      FS_OR:   r_o = a_i | b_i;
      FS_XOR:  r_o = a_i ^ b_i;
      FS_NOT:  r_o = ~a_i;
      FS_MOVB: r_o = b_i;
      FS_SHR: begin
        r_o = {1'b0, b_i[DW-1:1]};
        c_o = b_i[0];
      end
      FS_SHL: begin
        r_o = {b_i[DW-2:0], 1'b0};
        c_o = b_i[DW-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/func_unit_mc.sv
// Multi-cycle function unit: one-cycle ALU ops, iterative shift-add MUL.
// Results and flags are registered and strobed by a one-cycle done pulse.
module func_unit_mc
  import fu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MUL_CYC = DW
) (
  input  logic           clk,
  input  logic           rst,
  func_unit_mc_if.slave  io
);

  localparam int CW = $clog2(MUL_CYC + 1);

  state_e          state_q;
  logic [3:0]      fs_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [2*DW-1:0] p_q;
  logic [2*DW-1:0] p_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [DW-1:0]   f_q;
  logic            c_q;
  logic            v_q;
  logic            n_q;
  logic            z_q;

  logic [DW-1:0]   alu_r;
  logic            alu_c;
  logic            alu_v;
  logic [DW:0]     acc;
  logic            hi_nz;

  fu_alu_comb #(.DW(DW)) u_alu (
    .fs_i (fs_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .r_o  (alu_r),
    .c_o  (alu_c),
    .v_o  (alu_v)
  );

  // Low half of P holds the unconsumed multiplier bits.
  assign acc = {1'b0, p_q[2*DW-1:DW]}
             + (p_q[0] ? {1'b0, a_q} : '0);
  assign p_d   = {acc, p_q[DW-1:1]};
  assign hi_nz = |p_q[2*DW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fs_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io.start) begin
            fs_q    <= io.FS;
            a_q     <= io.A;
            b_q     <= io.B;
            p_q     <= {{DW{1'b0}}, io.B};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (io.FS == FS_MUL)
                     ? MUL : EXEC;
          end
        end
        EXEC: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          f_q     <= alu_r;
          c_q     <= alu_c;
          v_q     <= alu_v;
          n_q     <= alu_r[DW-1];
          z_q     <= (alu_r == '0);
        end
        MUL: begin
          // Final MUL cycle writes back the finished product.
          if (cnt_q == CW'(MUL_CYC)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            f_q     <= p_q[DW-1:0];
            c_q     <= hi_nz;
            v_q     <= hi_nz;
            n_q     <= p_q[DW-1];
            z_q     <= (p_q[DW-1:0] == '0);
          end else begin
            p_q   <= p_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.F    = f_q;
  assign io.C    = c_q;
  assign io.V    = v_q;
  assign io.N    = n_q;
  assign io.Z    = z_q;

endmodule

// File: tb/tb_func_unit_mc.sv
// Scoreboard bench: driver predicts results from an arithmetic model,
// a negedge monitor pops and compares on every done pulse.
module tb_func_unit_mc;

  localparam int MUL_LAT = 9;

  typedef struct {
    logic [7:0] f;
    logic c, v, n, z;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  func_unit_mc_if #(.DW(8)) io();

  func_unit_mc #(.DW(8), .MUL_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int ec = 0;
  int acc_e = -1;
  int busy_until = 0;
  int free_e = 0;
  int errors = 0;
  int checks = 0;
  logic [7:0] h_f = 8'h00;
  logic h_c = 1'b0, h_v = 1'b0;
  logic h_n = 1'b0, h_z = 1'b0;

  function automatic int sx(int u);
    return (u > 127) ? u - 256 : u;
  endfunction

  function automatic exp_t model(int fs, int a, int b);
    exp_t e;
    int x, y, ci, u, sv, r, p;
    bit c, v, arith;
    arith = 0; x = a; y = 0; ci = 0;
    r = 0; c = 0; v = 0;
    case (fs)
      0, 7: r = a;
      1: begin arith = 1; ci = 1; end
      2: begin arith = 1; y = b; end
      3: begin arith = 1; y = b; ci = 1; end
      4: begin arith = 1; y = 255 - b; end
      5: begin arith = 1; y = 255 - b; ci = 1; end
      6: begin arith = 1; y = 255; end
      8: r = a & b;
      9: r = a | b;
      10: r = a ^ b;
      11: r = 255 - a;
      12: r = b;
      13: begin r = b >> 1; c = b[0]; end
      14: begin r = (b << 1) & 255; c = b[7]; end
      default: begin
        p = a * b;
        r = p & 255;
        c = p > 255;
        v = c;
      end
    endcase
    if (arith) begin
      u  = x + y + ci;
      r  = u & 255;
      c  = u > 255;
      sv = sx(x) + sx(y) + ci;
      v  = (sv > 127) || (sv < -128);
    end
    e.f = r[7:0];
    e.c = c;
    e.v = v;
    e.n = r[7];
    e.z = (r == 0);
    e.due = 0;
    return e;
  endfunction

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h edge=%0d",
               nm, act, exp, ec);
    end
  endfunction

  function automatic void fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s edge=%0d", nm, ec);
  endfunction

  // Edge counter and reset effect on the model.
  always @(posedge clk) begin
    ec++;
    if (rst) begin
      sbq.delete();
      h_f = 8'h00;
      {h_c, h_v, h_n, h_z} = 4'b0;
      acc_e = -1;
      busy_until = 0;
      free_e = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (io.done === 1'b1) begin
      if (sbq.size() == 0) begin
        fail_now("spurious_done");
      end else begin
        e = sbq.pop_front();
        chk("done_time", ec, e.due);
        h_f = e.f;
        h_c = e.c; h_v = e.v;
        h_n = e.n; h_z = e.z;
      end
    end else begin
      chk("done_low", {31'b0, io.done}, 0);
      if (sbq.size() > 0 && sbq[0].due <= ec) begin
        fail_now("missed_done");
        void'(sbq.pop_front());
      end
    end
    chk("busy", {31'b0, io.busy},
        {31'b0, (ec >= acc_e && ec < busy_until)});
    chk("F", {24'b0, io.F}, {24'b0, h_f});
    chk("flags", {28'b0, io.C, io.V, io.N, io.Z},
        {28'b0, h_c, h_v, h_n, h_z});
  end

  task automatic drv(bit r, bit st, logic [3:0] fs,
                     logic [7:0] a, logic [7:0] b);
    exp_t x;
    int e, lat;
    @(posedge clk);
    #1;
    rst = r;
    io.start = st;
    io.FS = fs;
    io.A = a;
    io.B = b;
    e = ec + 1;
    if (!r && st && e >= free_e) begin
      lat = (fs == 4'hF) ? MUL_LAT : 1;
      x = model(int'(fs), int'(a), int'(b));
      x.due = e + lat;
      sbq.push_back(x);
      acc_e = e;
      busy_until = e + lat;
      free_e = e + lat + 1;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drv(0, 0, 4'h0, 8'h00, 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d", ec);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    io.start = 1'b0;
    io.FS = 4'h0;
    io.A = 8'h00;
    io.B = 8'h00;
    drv(1, 0, 4'h0, 8'h00, 8'h00);
    drv(1, 0, 4'h0, 8'h00, 8'h00);
    drv(0, 1, 4'h2, 8'h7F, 8'h01);
    idle(3);
    drv(0, 1, 4'h5, 8'h05, 8'h05);
    idle(2);
    drv(0, 1, 4'h5, 8'h00, 8'h01);
    idle(2);
    drv(0, 1, 4'hF, 8'h0D, 8'h0B);
    idle(11);
    drv(0, 1, 4'hF, 8'h10, 8'h10);
    idle(11);
    drv(0, 1, 4'hF, 8'hA5, 8'h3C);
    for (int i = 0; i < 9; i++)
      drv(0, i[0], 4'($urandom_range(0, 15)),
          8'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++)
      drv(0, 1, 4'h9, 8'h35, 8'hC2);
    idle(3);
    drv(0, 1, 4'hF, 8'hFF, 8'hFF);
    idle(3);
    drv(1, 0, 4'h0, 8'h00, 8'h00);
    idle(2);
    drv(0, 1, 4'hE, 8'h00, 8'h81);
    idle(3);
    drv(0, 1, 4'hD, 8'h00, 8'h81);
    drv(0, 1, 4'h6, 8'h80, 8'h00);
    drv(0, 1, 4'h6, 8'h80, 8'h00);
    idle(2);
    drv(0, 1, 4'h1, 8'hFF, 8'h00);
    idle(2);
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 149) == 0,
          $urandom_range(0, 2) != 0,
          4'($urandom_range(0, 15)),
          8'($urandom), 8'($urandom));
    for (int i = 0; i < 20 && sbq.size() > 0; i++)
      idle(1);
    idle(2);
    if (sbq.size() != 0)
      fail_now("drain_timeout");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
